id_stage: RTL

Instruction-decode stage of the MIPS core, directly downstream of instruction fetch. Latches the fetched instruction and its PC+4 into an IF/ID pipeline register with stall/flush control, and decodes the opcode into datapath controls. Also holds the 32×32 register file, which has a write-back port and a same-cycle write-to-read bypass. Outputs feed the execute stage and the fetch PC-select logic (branch and jump targets).

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/id_stage_regfile.sv | 45 ++++
 rtl/id_stage.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | mips_pkg : shared opcode/funct codes, ALU encodings, sizes   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_N  = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_LUI = 3'd7
   } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/id_stage_regfile.sv
`default_nettype none
// +--------------------------------------------------------------+
// | id_stage_regfile : 2R/1W register file with write bypass     |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module id_stage_regfile
   import mips_pkg::*;
#(
   parameter int DATA_W_P = DATA_W,
   parameter int REG_N_P  = REG_N
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [4:0]        RsAddr,
   input  logic [4:0]        RtAddr,
   output logic [DATA_W_P-1:0] RsData,
   output logic [DATA_W_P-1:0] RtData,
   input  logic              WE,
   input  logic [4:0]        WAddr,
   input  logic [DATA_W_P-1:0] WData
);

   logic [DATA_W_P-1:0] r_regs [REG_N_P];
   logic                w_wr;

   assign w_wr = WE && (WAddr != 5'd0);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < REG_N_P; i++) r_regs[i] <= '0;
      end else if (w_wr) begin
         r_regs[WAddr] <= WData;
      end
   end

   // $0 is hardwired; a same-cycle write to the read index wins over storage
   always_comb begin
      RsData = '0;
      RtData = '0;
      if (RsAddr != 5'd0) RsData = (w_wr && WAddr == RsAddr) ? WData : r_regs[RsAddr];
      if (RtAddr != 5'd0) RtData = (w_wr && WAddr == RtAddr) ? WData : r_regs[RtAddr];
   end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// +--------------------------------------------------------------+
// | id_stage : IF/ID register, opcode decode and register file   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module id_stage
   import mips_pkg::*;
#(
   parameter int DATA_W_P = DATA_W,
   parameter int REG_N_P  = REG_N
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                Stall,
   input  logic                Flush,
   input  logic [DATA_W_P-1:0] IfPC,
   input  logic [31:0]         IfIns,
   input  logic                WbWE,
   input  logic [4:0]          WbAddr,
   input  logic [DATA_W_P-1:0] WbData,
   output logic [DATA_W_P-1:0] IdPC,
   output logic                Valid,
   output logic [4:0]          Rs,
   output logic [4:0]          Rt,
   output logic [4:0]          WReg,
   output logic [DATA_W_P-1:0] RsData,
   output logic [DATA_W_P-1:0] RtData,
   output logic [31:0]         Imm,
   output logic [4:0]          Shamt,
   output logic [2:0]          AluOp,
   output logic                AluSrc,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                MemToReg,
   output logic                RegWrite,
   output logic                Link,
   output logic                Beq,
   output logic                Bne,
   output logic                Jump,
   output logic                JumpReg,
   output logic [31:0]         BrTarget,
   output logic [31:0]         JTarget,
   output logic                Illegal
);

   logic [31:0]         r_ins;
   logic [DATA_W_P-1:0] r_idpc;
   logic                r_valid;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_ins   <= '0;
         r_idpc  <= '0;
         r_valid <= 1'b0;
      end else if (Flush) begin
         r_ins   <= '0;
         r_valid <= 1'b0;
      end else if (!Stall) begin
         r_ins   <= IfIns;
         r_idpc  <= IfPC;
         r_valid <= 1'b1;
      end
   end

   logic [5:0]  w_op;
   logic [5:0]  w_fn;
   logic [15:0] w_imm16;
   logic [4:0]  w_rd;
   alu_op_t     w_aluop;

   assign w_op    = r_ins[31:26];
   assign w_fn    = r_ins[5:0];
   assign w_imm16 = r_ins[15:0];
   assign w_rd    = r_ins[15:11];

   assign IdPC     = r_idpc;
   assign Valid    = r_valid;
   assign Rs       = r_ins[25:21];
   assign Rt       = r_ins[20:16];
   assign Shamt    = r_ins[10:6];
   assign AluOp    = w_aluop;
   assign BrTarget = r_idpc + {{14{w_imm16[15]}}, w_imm16, 2'b00};
   assign JTarget  = {r_idpc[31:28], r_ins[25:0], 2'b00};

   id_stage_regfile #(
      .DATA_W_P (DATA_W_P),
      .REG_N_P  (REG_N_P)
   ) u_regfile (
      .CLK    (CLK),
      .RST    (RST),
      .RsAddr (r_ins[25:21]),
      .RtAddr (r_ins[20:16]),
      .RsData (RsData),
      .RtData (RtData),
      .WE     (WbWE),
      .WAddr  (WbAddr),
      .WData  (WbData)
   );

   // Unrecognised encodings keep every control at its zero default
   always_comb begin
      w_aluop  = ALU_ADD;
      AluSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      Link     = 1'b0;
      Beq      = 1'b0;
      Bne      = 1'b0;
      Jump     = 1'b0;
      JumpReg  = 1'b0;
      Illegal  = 1'b0;
      WReg     = r_ins[20:16];
      Imm      = {{16{w_imm16[15]}}, w_imm16};

      case (w_op)
         OP_RTYPE: begin
            WReg     = w_rd;
            RegWrite = 1'b1;
            case (w_fn)
               FN_ADD:  w_aluop = ALU_ADD;
               FN_SUB:  w_aluop = ALU_SUB;
               FN_AND:  w_aluop = ALU_AND;
               FN_OR:   w_aluop = ALU_OR;
               FN_SLT:  w_aluop = ALU_SLT;
               FN_SLL:  w_aluop = ALU_SLL;
               FN_SRL:  w_aluop = ALU_SRL;
               FN_JR: begin
                  RegWrite = 1'b0;
                  JumpReg  = 1'b1;
               end
               default: begin
                  RegWrite = 1'b0;
                  Illegal  = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin
            AluSrc = 1'b1; RegWrite = 1'b1;
         end
         OP_ANDI: begin
            AluSrc = 1'b1; RegWrite = 1'b1; w_aluop = ALU_AND;
            Imm    = {16'h0000, w_imm16};
         end
         OP_ORI: begin
            AluSrc = 1'b1; RegWrite = 1'b1; w_aluop = ALU_OR;
            Imm    = {16'h0000, w_imm16};
         end
         OP_LUI: begin
            AluSrc = 1'b1; RegWrite = 1'b1; w_aluop = ALU_LUI;
         end
         OP_LW: begin
            AluSrc = 1'b1; RegWrite = 1'b1; MemRead = 1'b1; MemToReg = 1'b1;
         end
         OP_SW: begin
            AluSrc = 1'b1; MemWrite = 1'b1;
         end
         OP_BEQ: begin
            Beq = 1'b1; w_aluop = ALU_SUB;
         end
         OP_BNE: begin
            Bne = 1'b1; w_aluop = ALU_SUB;
         end
         OP_J: Jump = 1'b1;
         OP_JAL: begin
            Jump = 1'b1; Link = 1'b1; RegWrite = 1'b1; WReg = 5'd31;
         end
         default: Illegal = 1'b1;
      endcase

      // A bubble must not disturb downstream state
      if (!r_valid) begin
         w_aluop  = ALU_ADD;
         AluSrc   = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         MemToReg = 1'b0;
         RegWrite = 1'b0;
         Link     = 1'b0;
         Beq      = 1'b0;
         Bne      = 1'b0;
         Jump     = 1'b0;
         JumpReg  = 1'b0;
         Illegal  = 1'b0;
      end
   end

endmodule
`default_nettype wire
